// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, dmem size selects,
// trap codes and FSM state constants, plus small decode helpers.
// No logic of its own; imported by every lsu_ctrl file.
package lsu_ctrl_pkg;

    // RISC-V load/store funct3 encodings (stores reuse the low two bits)
    typedef enum logic [2:0] {
        F3_B   = 3'b000,
        F3_H   = 3'b001,
        F3_W   = 3'b010,
        F3_D   = 3'b011,
        F3_BU  = 3'b100,
        F3_HU  = 3'b101,
        F3_WU  = 3'b110,
        F3_RSV = 3'b111
    } funct3_e;

    // dmem byte-lane select per access size
    localparam logic [7:0] SEL_B = 8'h01;
    localparam logic [7:0] SEL_H = 8'h03;
    localparam logic [7:0] SEL_W = 8'h0F;
    localparam logic [7:0] SEL_D = 8'hFF;

    // Trap cause codes; 4..7 originate in dmem and are passed through
    typedef enum logic [3:0] {
        EXC_ILLEGAL  = 4'd2,
        EXC_LD_MISAL = 4'd4,
        EXC_LD_FAULT = 4'd5,
        EXC_ST_MISAL = 4'd6,
        EXC_ST_FAULT = 4'd7
    } exc_e;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

    // Size field (funct3[1:0]) to dmem lane select
    function automatic logic [7:0] word_sel(input logic [1:0] size);
        case (size)
            2'd0:    return SEL_B;
            2'd1:    return SEL_H;
            2'd2:    return SEL_W;
            default: return SEL_D;
        endcase
    endfunction

    // Stores have no unsigned variants; loads have no 3'b111 encoding
    function automatic logic is_illegal(input logic is_store, input logic [2:0] f3);
        return is_store ? f3[2] : (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Bundle of every non-clock signal around the load/store unit.
// master = surrounding pipeline and dmem (execute, writeback, memory).
// slave  = lsu_ctrl itself.
interface lsu_ctrl_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    // execute -> lsu request
    logic            req_valid;
    logic            req_ready;
    logic            req_is_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [4:0]      req_rd;
    // lsu -> writeback response
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic [4:0]      rsp_rd;
    logic            rsp_exc_en;
    logic [3:0]      rsp_exc_code;
    logic [XLEN-1:0] rsp_exc_val;
    // pipeline redirect
    logic            flush;
    // lsu <-> dmem
    logic            we_dmem;
    logic            is_LOAD;
    logic [7:0]      dmem_word_sel;
    logic [XLEN-1:0] r_dmem_addr;
    logic [XLEN-1:0] w_dmem_data;
    logic [XLEN-1:0] dmem_data;
    logic            exc_en;
    logic [3:0]      exc_code;
    logic [XLEN-1:0] exc_val;
    // performance counters
    logic [CNT_W-1:0] cnt_load;
    logic [CNT_W-1:0] cnt_store;
    logic [CNT_W-1:0] cnt_exc;

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output rsp_ready, flush, dmem_data, exc_en, exc_code, exc_val,
        input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_exc_en, rsp_exc_code, rsp_exc_val,
        input  we_dmem, is_LOAD, dmem_word_sel, r_dmem_addr, w_dmem_data,
        input  cnt_load, cnt_store, cnt_exc
    );

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  rsp_ready, flush, dmem_data, exc_en, exc_code, exc_val,
        output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_exc_en, rsp_exc_code, rsp_exc_val,
        output we_dmem, is_LOAD, dmem_word_sel, r_dmem_addr, w_dmem_data,
        output cnt_load, cnt_store, cnt_exc
    );

endinterface

// File: rtl/lsu_ctrl_load_ext.sv
// Sign/zero extension of LSB-aligned dmem read data according to funct3.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module lsu_load_ext
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] raw_i,
    output logic [XLEN-1:0] ext_o
);

    // Pick the width from funct3[1:0], the fill bit from funct3[2]
    always_comb begin
        ext_o = raw_i;
        case (funct3_i)
            F3_B:    ext_o = {{(XLEN-8){raw_i[7]}},   raw_i[7:0]};
            F3_H:    ext_o = {{(XLEN-16){raw_i[15]}}, raw_i[15:0]};
            F3_W:    ext_o = {{(XLEN-32){raw_i[31]}}, raw_i[31:0]};
            F3_BU:   ext_o = {{(XLEN-8){1'b0}},       raw_i[7:0]};
            F3_HU:   ext_o = {{(XLEN-16){1'b0}},      raw_i[15:0]};
            F3_WU:   ext_o = {{(XLEN-32){1'b0}},      raw_i[31:0]};
            default: ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: one op per handshake, one-cycle dmem access, registered response.
// Latency: accept edge N, dmem access cycle N+1, rsp_valid from N+2 (illegal ops: N+1).
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready (flush wins).
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic clk,
    input  logic rst,
    lsu_ctrl_if.slave bus
);

    state_t           state_q,        state_d;
    logic             op_store_q,     op_store_d;
    logic [2:0]       op_f3_q,        op_f3_d;
    logic [XLEN-1:0]  op_addr_q,      op_addr_d;
    logic [XLEN-1:0]  op_wdata_q,     op_wdata_d;
    logic [4:0]       op_rd_q,        op_rd_d;
    logic [XLEN-1:0]  rsp_data_q,     rsp_data_d;
    logic [4:0]       rsp_rd_q,       rsp_rd_d;
    logic             rsp_exc_en_q,   rsp_exc_en_d;
    logic [3:0]       rsp_exc_code_q, rsp_exc_code_d;
    logic [XLEN-1:0]  rsp_exc_val_q,  rsp_exc_val_d;
    logic [CNT_W-1:0] cnt_load_q,     cnt_load_d;
    logic [CNT_W-1:0] cnt_store_q,    cnt_store_d;
    logic [CNT_W-1:0] cnt_exc_q,      cnt_exc_d;

    logic             in_access;
    logic [XLEN-1:0]  load_ext;

    lsu_load_ext #(.XLEN(XLEN)) u_load_ext (
        .funct3_i (op_f3_q),
        .raw_i    (bus.dmem_data),
        .ext_o    (load_ext)
    );

    // Next-state: request capture, dmem sampling, response retire and counting
    always_comb begin
        state_d        = state_q;
        op_store_d     = op_store_q;
        op_f3_d        = op_f3_q;
        op_addr_d      = op_addr_q;
        op_wdata_d     = op_wdata_q;
        op_rd_d        = op_rd_q;
        rsp_data_d     = rsp_data_q;
        rsp_rd_d       = rsp_rd_q;
        rsp_exc_en_d   = rsp_exc_en_q;
        rsp_exc_code_d = rsp_exc_code_q;
        rsp_exc_val_d  = rsp_exc_val_q;
        cnt_load_d     = cnt_load_q;
        cnt_store_d    = cnt_store_q;
        cnt_exc_d      = cnt_exc_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_store_d = bus.req_is_store;
                    op_f3_d    = bus.req_funct3;
                    op_addr_d  = bus.req_addr;
                    op_wdata_d = bus.req_wdata;
                    op_rd_d    = bus.req_rd;
                    // Undefined encodings trap without ever touching dmem
                    if (is_illegal(bus.req_is_store, bus.req_funct3)) begin
                        state_d        = ST_RESP;
                        rsp_data_d     = '0;
                        rsp_rd_d       = bus.req_is_store ? 5'd0 : bus.req_rd;
                        rsp_exc_en_d   = 1'b1;
                        rsp_exc_code_d = EXC_ILLEGAL;
                        rsp_exc_val_d  = bus.req_addr;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                // The dmem access happens regardless; flush only drops the result
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_RESP;
                    rsp_rd_d = op_store_q ? 5'd0 : op_rd_q;
                    if (bus.exc_en) begin
                        rsp_data_d     = '0;
                        rsp_exc_en_d   = 1'b1;
                        rsp_exc_code_d = bus.exc_code;
                        rsp_exc_val_d  = bus.exc_val;
                    end else begin
                        rsp_data_d     = op_store_q ? '0 : load_ext;
                        rsp_exc_en_d   = 1'b0;
                        rsp_exc_code_d = 4'd0;
                        rsp_exc_val_d  = '0;
                    end
                end
            end
            ST_RESP: begin
                if (bus.flush || bus.rsp_ready) begin
                    state_d        = ST_IDLE;
                    rsp_data_d     = '0;
                    rsp_rd_d       = 5'd0;
                    rsp_exc_en_d   = 1'b0;
                    rsp_exc_code_d = 4'd0;
                    rsp_exc_val_d  = '0;
                    // Only a response actually consumed by writeback is counted
                    if (!bus.flush) begin
                        if (rsp_exc_en_q)    cnt_exc_d   = cnt_exc_q   + CNT_W'(1);
                        else if (op_store_q) cnt_store_d = cnt_store_q + CNT_W'(1);
                        else                 cnt_load_d  = cnt_load_q  + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and response registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            op_store_q     <= 1'b0;
            op_f3_q        <= 3'd0;
            op_addr_q      <= '0;
            op_wdata_q     <= '0;
            op_rd_q        <= 5'd0;
            rsp_data_q     <= '0;
            rsp_rd_q       <= 5'd0;
            rsp_exc_en_q   <= 1'b0;
            rsp_exc_code_q <= 4'd0;
            rsp_exc_val_q  <= '0;
            cnt_load_q     <= '0;
            cnt_store_q    <= '0;
            cnt_exc_q      <= '0;
        end else begin
            state_q        <= state_d;
            op_store_q     <= op_store_d;
            op_f3_q        <= op_f3_d;
            op_addr_q      <= op_addr_d;
            op_wdata_q     <= op_wdata_d;
            op_rd_q        <= op_rd_d;
            rsp_data_q     <= rsp_data_d;
            rsp_rd_q       <= rsp_rd_d;
            rsp_exc_en_q   <= rsp_exc_en_d;
            rsp_exc_code_q <= rsp_exc_code_d;
            rsp_exc_val_q  <= rsp_exc_val_d;
            cnt_load_q     <= cnt_load_d;
            cnt_store_q    <= cnt_store_d;
            cnt_exc_q      <= cnt_exc_d;
        end
    end

    // dmem side is gated by the ACCESS state so it reads zero at all other times
    assign in_access         = (state_q == ST_ACCESS);
    assign bus.we_dmem       = in_access &&  op_store_q;
    assign bus.is_LOAD       = in_access && !op_store_q;
    assign bus.dmem_word_sel = in_access ? word_sel(op_f3_q[1:0]) : 8'h00;
    assign bus.r_dmem_addr   = in_access ? op_addr_q  : '0;
    assign bus.w_dmem_data   = in_access ? op_wdata_q : '0;

    assign bus.req_ready     = (state_q == ST_IDLE);
    assign bus.rsp_valid     = (state_q == ST_RESP);
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_rd        = rsp_rd_q;
    assign bus.rsp_exc_en    = rsp_exc_en_q;
    assign bus.rsp_exc_code  = rsp_exc_code_q;
    assign bus.rsp_exc_val   = rsp_exc_val_q;
    assign bus.cnt_load      = cnt_load_q;
    assign bus.cnt_store     = cnt_store_q;
    assign bus.cnt_exc       = cnt_exc_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: 8 KiB little-endian dmem model, transaction-level reference model,
// a per-cycle comparator, and directed ops with hand-computed results.
module tb_lsu_ctrl;

    localparam int XLEN      = 64;
    localparam int CNT_W     = 32;
    localparam int MEM_BYTES = 8192;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        exc_en;
        logic [3:0]  code;
        logic [63:0] val;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lsu_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
    lsu_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- dmem environment: bounds fault first, then alignment ----------------
    logic [7:0] dmem_mem [0:MEM_BYTES-1];
    int dm_sz;
    int dm_base;
    int we_count = 0;

    always_comb begin
        bus.exc_en    = 1'b0;
        bus.exc_code  = 4'd0;
        bus.exc_val   = '0;
        bus.dmem_data = '0;
        dm_base       = 0;
        case (bus.dmem_word_sel)
            8'h01:   dm_sz = 1;
            8'h03:   dm_sz = 2;
            8'h0F:   dm_sz = 4;
            8'hFF:   dm_sz = 8;
            default: dm_sz = 0;
        endcase
        if ((bus.we_dmem || bus.is_LOAD) && dm_sz != 0) begin
            if (bus.r_dmem_addr > 64'(MEM_BYTES - dm_sz)) begin
                bus.exc_en   = 1'b1;
                bus.exc_code = bus.we_dmem ? 4'd7 : 4'd5;
                bus.exc_val  = bus.r_dmem_addr;
            end else if ((bus.r_dmem_addr & 64'(dm_sz - 1)) != 0) begin
                bus.exc_en   = 1'b1;
                bus.exc_code = bus.we_dmem ? 4'd6 : 4'd4;
                bus.exc_val  = bus.r_dmem_addr;
            end else begin
                dm_base = int'(bus.r_dmem_addr[15:0]);
                for (int i = 0; i < 8; i++)
                    if (i < dm_sz) bus.dmem_data[8*i +: 8] = dmem_mem[dm_base + i];
            end
        end
    end

    always @(posedge clk) begin
        if (bus.we_dmem) we_count <= we_count + 1;
        if (bus.we_dmem && !bus.exc_en)
            for (int i = 0; i < 8; i++)
                if (i < dm_sz) dmem_mem[dm_base + i] <= bus.w_dmem_data[8*i +: 8];
    end

    // ---------------- reference model: one op in flight, tracked by age ----------------
    logic [7:0]       model_mem [logic [63:0]];
    bit               m_busy = 0;
    int               m_age = 0;
    bit               m_illegal = 0;
    bit               m_store = 0;
    logic [2:0]       m_f3 = 0;
    logic [63:0]      m_addr = 0;
    logic [63:0]      m_wdata = 0;
    rsp_t             m_rsp = '0;
    logic [CNT_W-1:0] m_cnt_load = 0, m_cnt_store = 0, m_cnt_exc = 0;

    function automatic rsp_t predict(input bit st, input logic [2:0] f3,
                                     input logic [63:0] addr, input logic [4:0] rd);
        rsp_t r;
        int sz;
        logic [63:0] raw;
        sz     = 1 << f3[1:0];
        r      = '0;
        r.rd   = st ? 5'd0 : rd;
        if (st ? f3[2] : (f3 == 3'b111)) begin
            r.exc_en = 1'b1; r.code = 4'd2; r.val = addr;
        end else if (addr + 64'(sz) > 64'(MEM_BYTES)) begin
            r.exc_en = 1'b1; r.code = st ? 4'd7 : 4'd5; r.val = addr;
        end else if (addr % 64'(sz) != 0) begin
            r.exc_en = 1'b1; r.code = st ? 4'd6 : 4'd4; r.val = addr;
        end else if (!st) begin
            raw = 0;
            for (int i = 0; i < sz; i++)
                if (model_mem.exists(addr + 64'(i))) raw[8*i +: 8] = model_mem[addr + 64'(i)];
            if (sz < 8 && !f3[2] && raw[8*sz-1]) raw = raw - (64'd1 << (8*sz));
            r.data = raw;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0; m_age = 0;
            m_cnt_load = 0; m_cnt_store = 0; m_cnt_exc = 0;
        end else if (!m_busy) begin
            if (bus.req_valid) begin
                m_store   = bus.req_is_store;
                m_f3      = bus.req_funct3;
                m_addr    = bus.req_addr;
                m_wdata   = bus.req_wdata;
                m_illegal = m_store ? m_f3[2] : (m_f3 == 3'b111);
                m_rsp     = predict(m_store, m_f3, m_addr, bus.req_rd);
                m_busy    = 1; m_age = 1;
            end
        end else if (m_age >= (m_illegal ? 1 : 2)) begin
            if (bus.flush) m_busy = 0;
            else if (bus.rsp_ready) begin
                if (m_rsp.exc_en) m_cnt_exc++;
                else if (m_store) m_cnt_store++;
                else m_cnt_load++;
                m_busy = 0;
            end
        end else begin
            if (m_store && !m_rsp.exc_en)
                for (int i = 0; i < (1 << m_f3[1:0]); i++) model_mem[m_addr + 64'(i)] = m_wdata[8*i +: 8];
            if (bus.flush) m_busy = 0; else m_age = 2;
        end
    end

    // ---------------- per-cycle comparator ----------------
    bit         exp_valid, exp_drive;
    logic [7:0] exp_sel;
    always @(negedge clk) begin
        exp_valid = m_busy && (m_age >= (m_illegal ? 1 : 2));
        exp_drive = m_busy && !m_illegal && (m_age == 1);
        exp_sel   = exp_drive ? 8'((1 << (1 << m_f3[1:0])) - 1) : 8'h00;
        chk("req_ready", 64'(bus.req_ready), 64'(!m_busy));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_valid));
        if (exp_valid) begin
            chk("rsp_data",     bus.rsp_data,           m_rsp.data);
            chk("rsp_rd",       64'(bus.rsp_rd),        64'(m_rsp.rd));
            chk("rsp_exc_en",   64'(bus.rsp_exc_en),    64'(m_rsp.exc_en));
            chk("rsp_exc_code", 64'(bus.rsp_exc_code),  64'(m_rsp.code));
            chk("rsp_exc_val",  bus.rsp_exc_val,        m_rsp.val);
        end
        chk("we_dmem",       64'(bus.we_dmem),       64'(exp_drive && m_store));
        chk("is_LOAD",       64'(bus.is_LOAD),       64'(exp_drive && !m_store));
        chk("dmem_word_sel", 64'(bus.dmem_word_sel), 64'(exp_sel));
        if (exp_drive) chk("r_dmem_addr", bus.r_dmem_addr, m_addr);
        if (exp_drive && m_store) chk("w_dmem_data", bus.w_dmem_data, m_wdata);
        chk("cnt_load",  64'(bus.cnt_load),  64'(m_cnt_load));
        chk("cnt_store", 64'(bus.cnt_store), 64'(m_cnt_store));
        chk("cnt_exc",   64'(bus.cnt_exc),   64'(m_cnt_exc));
    end

    // ---------------- stimulus ----------------
    // mode 0: normal retire, 1: flush during ACCESS, 2: flush during RESP
    task automatic run_op(input bit st, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [4:0] rd, input int hold,
                          input int mode, output rsp_t got, output int lat);
        got = '0;
        lat = 0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_is_store = st; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata; bus.req_rd = rd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (mode == 1) begin
            bus.flush = 1'b1;
            @(posedge clk); #1;
            bus.flush = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
                chk("no_rsp_after_flush", 64'(bus.rsp_valid), 64'd0);
            end
            return;
        end
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.rsp_valid) begin
            chk("rsp_valid_timeout", 64'(bus.rsp_valid), 64'd1);
            return;
        end
        got.data = bus.rsp_data; got.rd = bus.rsp_rd; got.exc_en = bus.rsp_exc_en;
        got.code = bus.rsp_exc_code; got.val = bus.rsp_exc_val;
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("hold_rsp_data",  bus.rsp_data, got.data);
            chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
        end
        if (mode == 2) bus.flush = 1'b1; else bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rsp_t r;
        int   lat, wc, ld_before;
        bus.req_valid = 0; bus.req_is_store = 0; bus.req_funct3 = 0; bus.req_addr = 0;
        bus.req_wdata = 0; bus.req_rd = 0; bus.rsp_ready = 0; bus.flush = 0;

        repeat (2) @(posedge clk); #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_we_dmem",   64'(bus.we_dmem),   64'd0);
        chk("rst_cnt_load",  64'(bus.cnt_load),  64'd0);
        @(negedge clk) rst = 1'b1;

        // SD then LB / LBU / LD of the same doubleword
        run_op(1, 3'b011, 64'h10, 64'h8000_0000_0000_00F0, 5'd0, 0, 0, r, lat);
        chk("sd_lat", 64'(lat), 64'd2);
        chk("sd_exc", 64'(r.exc_en), 64'd0);
        run_op(0, 3'b000, 64'h10, 64'h0, 5'd5, 0, 0, r, lat);
        chk("lb_data", r.data, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("lb_rd", 64'(r.rd), 64'd5);
        chk("lb_lat", 64'(lat), 64'd2);
        run_op(0, 3'b100, 64'h10, 64'h0, 5'd6, 0, 0, r, lat);
        chk("lbu_data", r.data, 64'h0000_0000_0000_00F0);
        run_op(0, 3'b011, 64'h10, 64'h0, 5'd7, 0, 0, r, lat);
        chk("ld_data", r.data, 64'h8000_0000_0000_00F0);

        // Misaligned load and faulting store
        run_op(0, 3'b010, 64'h12, 64'h0, 5'd8, 0, 0, r, lat);
        chk("lw_mis_exc",  64'(r.exc_en), 64'd1);
        chk("lw_mis_code", 64'(r.code), 64'd4);
        chk("lw_mis_val",  r.val, 64'h12);
        chk("lw_mis_data", r.data, 64'h0);
        chk("lw_mis_cnt_exc", 64'(bus.cnt_exc), 64'd1);
        run_op(1, 3'b000, 64'h1FFF, 64'h5A, 5'd0, 0, 0, r, lat);
        run_op(1, 3'b001, 64'h1FFF, 64'h1234, 5'd0, 0, 0, r, lat);
        chk("sh_fault_code", 64'(r.code), 64'd7);
        chk("sh_fault_mem",  64'(dmem_mem[16'h1FFF]), 64'h5A);

        // Illegal store encoding: trap in one cycle, dmem never written
        wc = we_count;
        run_op(1, 3'b100, 64'h40, 64'h1, 5'd3, 0, 0, r, lat);
        chk("ill_st_code", 64'(r.code), 64'd2);
        chk("ill_st_val",  r.val, 64'h40);
        chk("ill_st_lat",  64'(lat), 64'd1);
        chk("ill_st_no_we", 64'(we_count), 64'(wc));

        // Writeback stall for 5 cycles
        ld_before = int'(bus.cnt_load);
        run_op(0, 3'b010, 64'h14, 64'h0, 5'd9, 5, 0, r, lat);
        chk("lw_hold_data", r.data, 64'hFFFF_FFFF_8000_0000);
        chk("lw_hold_cnt_once", 64'(bus.cnt_load), 64'(ld_before + 1));
        chk("lw_hold_cnt_load", 64'(bus.cnt_load), 64'd4);

        // Flushed store still commits, its response is dropped
        run_op(1, 3'b010, 64'h20, 64'h0000_0000_DEAD_BEEF, 5'd0, 0, 1, r, lat);
        chk("flush_cnt_store", 64'(bus.cnt_store), 64'd2);
        chk("flush_cnt_exc",   64'(bus.cnt_exc),   64'd3);
        run_op(0, 3'b110, 64'h20, 64'h0, 5'd10, 0, 0, r, lat);
        chk("lwu_data", r.data, 64'h0000_0000_DEAD_BEEF);

        // Illegal load encoding keeps its destination
        run_op(0, 3'b111, 64'h30, 64'h0, 5'd7, 0, 0, r, lat);
        chk("ill_ld_code", 64'(r.code), 64'd2);
        chk("ill_ld_rd",   64'(r.rd), 64'd7);
        chk("ill_ld_lat",  64'(lat), 64'd1);

        // Halfword sign vs zero extension
        run_op(0, 3'b001, 64'h16, 64'h0, 5'd11, 0, 0, r, lat);
        chk("lh_data", r.data, 64'hFFFF_FFFF_FFFF_8000);
        run_op(0, 3'b101, 64'h16, 64'h0, 5'd12, 0, 0, r, lat);
        chk("lhu_data", r.data, 64'h0000_0000_0000_8000);

        // Flush while the response is waiting
        run_op(0, 3'b000, 64'h10, 64'h0, 5'd13, 1, 2, r, lat);
        chk("flush_rsp_cnt_load", 64'(bus.cnt_load), 64'd7);
        chk("flush_rsp_ready",    64'(bus.req_ready), 64'd1);

        // Asynchronous reset while in RESP
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_funct3 = 3'b011;
        bus.req_addr = 64'h10; bus.req_rd = 5'd4;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("arst_rsp_data",  bus.rsp_data, 64'h0);
        chk("arst_cnt_load",  64'(bus.cnt_load),  64'd0);
        chk("arst_cnt_store", 64'(bus.cnt_store), 64'd0);
        chk("arst_cnt_exc",   64'(bus.cnt_exc),   64'd0);
        chk("arst_we_dmem",   64'(bus.we_dmem),   64'd0);
        chk("arst_is_LOAD",   64'(bus.is_LOAD),   64'd0);
        chk("arst_word_sel",  64'(bus.dmem_word_sel), 64'd0);
        chk("arst_addr",      bus.r_dmem_addr, 64'h0);
        chk("arst_wdata",     bus.w_dmem_data, 64'h0);
        chk("arst_req_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
        run_op(0, 3'b100, 64'h10, 64'h0, 5'd1, 0, 0, r, lat);
        chk("post_rst_lbu", r.data, 64'h0000_0000_0000_00F0);
        chk("post_rst_cnt_load", 64'(bus.cnt_load), 64'd1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator that sits between the execute stage and dmem, driving dmem's request interface.
- Accepts one memory op per valid/ready handshake and encodes size into dmem_word_sel.
- Issues the access for exactly one cycle, then samples dmem's combinational read data and exception outputs.
- Sign/zero-extends loads and returns a registered response (data or trap info) to writeback.

Parameters:
XLEN, 64, data/address width
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req_valid  in  1  execute presents a memory op
req_ready  out  1  lsu can accept (high only in IDLE)
req_is_store  in  1  1=store, 0=load
req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD)
req_addr  in  XLEN  effective address
req_wdata  in  XLEN  store data
req_rd  in  5  load destination register
rsp_valid  out  1  response available
rsp_ready  in  1  writeback accepts response
rsp_data  out  XLEN  extended load result (0 for stores/traps)
rsp_rd  out  5  destination register (0 for stores)
rsp_exc_en / rsp_exc_code / rsp_exc_val  out  1/4/XLEN  trap info
flush  in  1  kill in-flight op (pipeline redirect)
we_dmem  out  1  dmem store enable
is_LOAD  out  1  dmem load strobe
dmem_word_sel  out  8  size select: 0x01/0x03/0x0F/0xFF
r_dmem_addr  out  XLEN  dmem address
w_dmem_data  out  XLEN  dmem store data
dmem_data  in  XLEN  dmem combinational read data (LSB-aligned)
exc_en / exc_code / exc_val  in  1/4/XLEN  dmem exception outputs
cnt_load / cnt_store / cnt_exc  out  CNT_W each  performance counters

Behaviour:
- Reset (rst=0, async): state=IDLE; req_ready=1; rsp_valid=0; all rsp_* and dmem-side outputs 0; counters 0.
- States: IDLE, ACCESS, RESP.
- IDLE: req_valid & req_ready latches request.
  - Legal op -> ACCESS.
  - Illegal funct3 (store with funct3[2]=1, or load funct3=3'b111) -> RESP directly with exc_en=1, code=2, val=req_addr; dmem is never driven.
- ACCESS (exactly 1 cycle): drive r_dmem_addr, w_dmem_data, dmem_word_sel from funct3[1:0] (0->0x01, 1->0x03, 2->0x0F, 3->0xFF).
  - Store: we_dmem=1, is_LOAD=0. Load: is_LOAD=1, we_dmem=0.
  - At the closing edge, sample dmem_data/exc_* into rsp regs -> RESP.
  - The store commits at that same edge unless dmem reports exc_en.
  - Outside ACCESS, we_dmem, is_LOAD and dmem_word_sel are 0.
- Load extension: funct3[2]=0 sign-extends from bit 7/15/31; funct3[2]=1 zero-extends. LD passes through unchanged.
- On exception: rsp_data=0; rsp_exc_code/val copied from dmem (4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault).
- RESP: rsp_valid=1; outputs held stable until rsp_ready. rsp_valid & rsp_ready -> IDLE. No new request is accepted in the same cycle.
- Latency: accept at edge N, ACCESS cycle N+1, rsp_valid at N+2. Minimum 3 cycles per op.
- flush:
  - In IDLE: no effect.
  - In ACCESS: the dmem access still occurs (store is not cancelled), the response is discarded, next state is IDLE.
  - In RESP: drops rsp_valid -> IDLE.
  - flush has priority over rsp_ready.
- Counters: increment at response acceptance only (not on flush).
  - cnt_load/cnt_store count ops without exception.
  - cnt_exc counts any trapped op.
  - Counters wrap modulo 2^CNT_W.
- Reset mid-op: immediate return to IDLE. A store in ACCESS whose edge coincides with reset assertion is not guaranteed to commit.

Decomposition:
- Shared package holds:
  - funct3 encodings
  - word_sel constants (SEL_B/H/W/D)
  - exception codes (EXC_ILLEGAL=2, LD_MISAL=4, LD_FAULT=5, ST_MISAL=6, ST_FAULT=7)
  - FSM state enum
- One sub-module, lsu_load_ext: purely combinational; funct3 + raw data -> extended XLEN result.

Test Plan:
- Write 0x8000_0000_0000_00F0 with SD at 0x10, then LB at 0x10 -> rsp_data=0xFFFF_FFFF_FFFF_FFF0. Then LBU at 0x10 -> 0xF0. Then LD at 0x10 -> original value. Each rsp_valid 2 cycles after accept.
- LW at 0x12 -> rsp_exc_en=1, code=4, val=0x12, rsp_data=0, cnt_exc=1. SH at 0x1FFF -> code=7, memory at 0x1FFF unchanged.
- req_is_store=1, funct3=3'b100 -> code=2, we_dmem never asserted, rsp_valid 1 cycle after accept.
- Hold rsp_ready=0 for 5 cycles after a load -> rsp_* stable and req_ready=0 throughout. Release -> IDLE; cnt_load increments once.
- SW 0xDEADBEEF at 0x20 with flush in ACCESS -> no rsp_valid, counters unchanged; subsequent LWU at 0x20 -> 0xDEADBEEF.
- Assert rst low asynchronously in RESP -> rsp_valid, counters and all dmem-side outputs go to 0 without a clock edge; req_ready=1 after release.
